// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between a memory master (processor memory port or
// bench) and the mem_responder target.
//   req    master->slave  request valid
//   ready  slave->master  target can accept a request this cycle
//   we     master->slave  1 = store, 0 = load
//   addr   master->slave  byte address
//   wdata  master->slave  store data
//   be     master->slave  store byte enables, be[i] covers wdata[8i+7:8i]
//   rvalid slave->master  one-cycle response pulse
//   rdata  slave->master  response data, held between responses
//   err    slave->master  response error flag, qualified by rvalid
// ---------------------------------------------------------------------------
interface mem_responder_if;
    logic        req;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Word-addressed memory target with a fixed response latency. A request is
// accepted on a rising edge with req=1 and ready=1; the response (rvalid
// pulse, rdata, err) is sampled by the master LATENCY edges later.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset (storage array is not cleared)
//   bus    mem_responder_if.slave (req/ready/we/addr/wdata/be/rvalid/rdata/err)
//
// Parameters:
//   DEPTH_LOG2  log2 of the number of 32-bit words (addresses wrap)
//   LATENCY     accept edge to rvalid-sampling edge, 1..15
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   : addr[1:0] != 0 gives err=1, no write, rdata held
//   undefined : addr[1:0] ignored, err always 0
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    we_q, we_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
`ifdef MISALIGN_CHECK_EN
    logic                    misalign_q, misalign_d;
`endif

    logic [31:0]             mem_q [0:(1<<DEPTH_LOG2)-1];

    logic                    accept;
    logic                    commit;
    logic                    use_live;
    logic                    op_we;
    logic [DEPTH_LOG2-1:0]   op_idx;
    logic [31:0]             op_wdata;
    logic [3:0]              op_be;
    logic                    op_misalign;
    logic [31:0]             old_word;
    logic [31:0]             merged_word;
    logic                    mem_wr;
    logic                    unused_addr_bits;

    // Upper address bits wrap away; low bits only matter with the check on.
    assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

    assign accept = bus.req && (state_q == IDLE);

    // With LATENCY=1 the commit happens on the accept edge itself, so the
    // operands must come straight from the bus rather than the capture regs.
    assign use_live = (state_q == IDLE);
    assign commit   = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request capture registers carry no reset: they are only read after an
    // accept has loaded them.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
`ifdef MISALIGN_CHECK_EN
        misalign_q <= misalign_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[op_idx] <= merged_word;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- capture and datapath ----------------
    always_comb begin
        we_d    = accept ? bus.we : we_q;
        idx_d   = accept ? bus.addr[DEPTH_LOG2+1:2] : idx_q;
        wdata_d = accept ? bus.wdata : wdata_q;
        be_d    = accept ? bus.be : be_q;

        op_we    = use_live ? bus.we : we_q;
        op_idx   = use_live ? bus.addr[DEPTH_LOG2+1:2] : idx_q;
        op_wdata = use_live ? bus.wdata : wdata_q;
        op_be    = use_live ? bus.be : be_q;
`ifdef MISALIGN_CHECK_EN
        misalign_d  = accept ? (bus.addr[1:0] != 2'b00) : misalign_q;
        op_misalign = use_live ? (bus.addr[1:0] != 2'b00) : misalign_q;
`else
        op_misalign = 1'b0;
`endif

        old_word    = mem_q[op_idx];
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (op_be[i]) begin
                merged_word[8*i +: 8] = op_wdata[8*i +: 8];
            end
        end

        mem_wr  = commit && op_we && !op_misalign;

        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d = op_misalign;
            if (!op_misalign) begin
                rdata_d = op_we ? merged_word : old_word;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.ready  = (state_q == IDLE);
        bus.rvalid = (state_q == RESP);
        bus.rdata  = rdata_q;
        bus.err    = err_q;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory target that answers load/store requests from the processor datapath's memory port.
- Accepts a request through a valid/ready handshake and returns read data plus an acknowledge pulse after a fixed, parameterised latency.
- Lets the core and bench exercise multi-cycle memory timing instead of an ideal zero-latency RAM.

Parameters:
- DEPTH_LOG2, 6, log2 of the number of 32-bit words stored (default 64 words).
- LATENCY, 2, cycles from the accept edge to the rvalid edge; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid.
- ready  output  1  responder can accept a request this cycle.
- we  input  1  1 = store, 0 = load; sampled at accept.
- addr  input  32  byte address; sampled at accept.
- wdata  input  32  store data; sampled at accept.
- be  input  4  store byte enables, be[i] covers wdata[8i+7:8i]; sampled at accept.
- rvalid  output  1  one-cycle response pulse.
- rdata  output  32  response data, valid while rvalid=1, held afterwards.
- err  output  1  response error flag, qualified by rvalid.

Behaviour:
- Reset values: state=IDLE, ready=1, rvalid=0, rdata=0, err=0, latency counter=0.
- Reset does not clear the storage array; contents are undefined until written.
- Accept: req=1 and ready=1 at a rising edge. The edge captures we, addr, wdata and be into internal registers.
- ready is 1 only in IDLE. In WAIT and RESP, req is ignored and inputs are not sampled.
- FSM states: IDLE, WAIT, RESP.
- IDLE -> RESP on accept when LATENCY=1; otherwise IDLE -> WAIT and the counter loads LATENCY-2.
- WAIT: the counter decrements each cycle. WAIT -> RESP on the edge where the counter equals 0.
- RESP -> IDLE unconditionally after one cycle.
- rvalid is registered and equals 1 exactly in RESP. It rises LATENCY edges after the accept edge.
- Throughput: one request per LATENCY+1 cycles. A held req is accepted again on the first edge with ready=1, i.e. the edge after RESP.
- Word index is addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2. addr[1:0] is handled per MISALIGN_CHECK_EN.
- The store commits on the edge entering RESP. Only bytes with be[i]=1 are updated; be=0000 leaves memory unchanged but still produces a response.
- Store response: rdata is the merged word after the write.
- Load response: rdata is the word read at the RESP-entry edge, so it reflects any store committed by earlier requests. be is ignored for loads.
- rdata holds its value until the next response and is never cleared except by reset.
- Reset mid-operation (WAIT or RESP): the pending request is dropped, no write commits, and outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined: a captured addr[1:0] != 00 produces a response with err=1 on the normal schedule. No memory write occurs and rdata keeps its previous value.
- Not defined: addr[1:0] is ignored, the access proceeds normally, and err is tied to 0.

Test Plan:
- Reset then idle -> ready=1, rvalid=0, rdata=0, err=0; assert reset during WAIT -> rvalid never pulses and ready=1 while reset is held.
- LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=1111 at edge T -> rvalid=1 only in cycle T+2, rdata=0xDEADBEEF, ready=0 for cycles T+1..T+2.
- Load addr=0x10 after the store -> rdata=0xDEADBEEF with rvalid exactly LATENCY edges after accept; req held high -> next accept on the edge after RESP.
- Partial store addr=0x10, wdata=0x000000AA, be=0001 -> response rdata=0xDEADBEAA; a following load of 0x10 returns 0xDEADBEAA.
- Wrap: DEPTH_LOG2=6, store 0x12345678 at addr=0x100 -> a load of addr=0x000 returns 0x12345678.
- MISALIGN_CHECK_EN defined: store to addr=0x11 -> rvalid with err=1, and a load of 0x10 still returns 0xDEADBEAA. Undefined: the same store writes word 0x10 and err=0.
